// File: rtl/rgbled_ctrl.sv
// rtl/rgbled_ctrl.sv - WS281x frame sequencer: colour table, frame streaming, latch gap, auto-refresh
//
// Holds a staging colour table written by the system. On each frame request the
// staging table is snapshotted into an active table, which is then streamed LED
// by LED to ws281x_drv over a valid/ack/last handshake. After the driver reports
// idle, a latch gap of GapCycles is enforced before the next frame may start.
// An optional free-running refresh counter re-requests the frame periodically.
//
// Ports:
//   clk_i         clock (same domain as ws281x_drv)
//   rst_ni        asynchronous reset, active low
//   led_we_i      colour write strobe into the staging table
//   led_idx_i     LED index for the write (indices >= NumLeds are ignored)
//   led_rgb_i     colour {R,G,B}
//   update_i      frame request pulse
//   busy_o        sequencer not idle, or a frame request is pending
//   go_o          frame in progress, to driver go_i
//   data_o        current LED colour in {G,R,B} wire order, zero outside SEND
//   data_valid_o  data_o holds a colour for the driver
//   data_last_o   data_o is the final LED of the frame
//   data_ack_i    driver has taken data_o
//   idle_i        driver has finished shifting out the frame

module rgbled_ctrl #(
  parameter int NumLeds       = 2,
  parameter int GapCycles     = 2400,
  parameter int RefreshCycles = 0,
  localparam int IdxW         = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            led_we_i,
  input  logic [IdxW-1:0] led_idx_i,
  input  logic [23:0]     led_rgb_i,
  input  logic            update_i,
  output logic            busy_o,
  output logic            go_o,
  output logic [23:0]     data_o,
  output logic            data_valid_o,
  output logic            data_last_o,
  input  logic            data_ack_i,
  input  logic            idle_i
);

  localparam int GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam int RefW = (RefreshCycles > 1) ? $clog2(RefreshCycles) : 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(GapCycles - 1);
  localparam logic [RefW-1:0] RefLast = RefW'((RefreshCycles > 0) ? RefreshCycles - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_IDLE = 2'd2,
    S_GAP       = 2'd3
  } state_e;

  // WS281x parts expect green first on the wire.
  function automatic logic [23:0] to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [IdxW-1:0] idx_nxt;
  logic [GapW-1:0] gap_q;
  logic [RefW-1:0] ref_q;
  logic            refresh_tc;
  logic            pending_q;
  logic            pending_d;
  logic            go_q;
  logic            valid_q;
  logic            last_q;
  logic [23:0]     data_q;
  logic [23:0]     staging_q [NumLeds];
  logic [23:0]     active_q  [NumLeds];

  assign idx_nxt      = idx_q + 1'b1;
  assign refresh_tc   = (RefreshCycles > 0) && (ref_q == RefLast);

  assign go_o         = go_q;
  assign data_valid_o = valid_q;
  assign data_last_o  = last_q;
  assign data_o       = data_q;
  assign busy_o       = (state_q != S_IDLE) | pending_q;

  // Staging table: system-side writes, out-of-range indices dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumLeds; i++) begin
        staging_q[i] <= '0;
      end
    end else if (led_we_i && (int'(led_idx_i) < NumLeds)) begin
      staging_q[led_idx_i] <= led_rgb_i;
    end
  end

  // Free-running refresh timer; its terminal count requests a frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q <= '0;
    end else if (RefreshCycles > 0) begin
      if (ref_q == RefLast) begin
        ref_q <= '0;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
    end else begin
      ref_q <= '0;
    end
  end

  // Requests from any source collapse into one pending flag, so coincident
  // update/refresh (or repeated updates during a frame) yield one frame.
  // Starting a frame consumes the request.
  always_comb begin
    pending_d = pending_q | update_i | refresh_tc;
    if ((state_q == S_IDLE) && pending_q) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Frame sequencer with registered driver-side outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      go_q    <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < NumLeds; i++) begin
        active_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            // Snapshot so later writes cannot disturb the frame in flight.
            for (int i = 0; i < NumLeds; i++) begin
              active_q[i] <= staging_q[i];
            end
            idx_q   <= '0;
            go_q    <= 1'b1;
            valid_q <= 1'b1;
            data_q  <= to_grb(staging_q[0]);
            last_q  <= (LastIdx == '0);
            state_q <= S_SEND;
          end
        end

        S_SEND: begin
          if (data_ack_i) begin
            if (last_q) begin
              go_q    <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= '0;
              state_q <= S_WAIT_IDLE;
            end else begin
              idx_q  <= idx_nxt;
              data_q <= to_grb(active_q[idx_nxt]);
              last_q <= (idx_nxt == LastIdx);
            end
          end
        end

        S_WAIT_IDLE: begin
          // The driver still shifts the final word; the latch gap is
          // timed from when the line actually goes quiet.
          if (idle_i) begin
            gap_q   <= GapLoad;
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgbled_ctrl.sv
// tb/tb_rgbled_ctrl.sv - directed and randomized self-checking bench for rgbled_ctrl

module tb_rgbled_ctrl;

  localparam int N   = 3;
  localparam int GAP = 8;
  localparam int REF = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        led_we;
  logic [1:0]  led_idx;
  logic [23:0] led_rgb;
  logic        update;
  logic        busy, go, valid, last, ack, idle;
  logic [23:0] data;

  logic        rst_r_n;
  logic        led_we_r;
  logic [0:0]  led_idx_r;
  logic [23:0] led_rgb_r;
  logic        update_r;
  logic        busy_r, go_r, valid_r, last_r, ack_r, idle_r;
  logic [23:0] data_r;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [23:0] stg  [N];
  logic [23:0] snap [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgbled_ctrl #(.NumLeds(N), .GapCycles(GAP), .RefreshCycles(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .led_we_i(led_we), .led_idx_i(led_idx),
    .led_rgb_i(led_rgb), .update_i(update), .busy_o(busy), .go_o(go),
    .data_o(data), .data_valid_o(valid), .data_last_o(last),
    .data_ack_i(ack), .idle_i(idle)
  );

  rgbled_ctrl #(.NumLeds(1), .GapCycles(4), .RefreshCycles(REF)) dut_r (
    .clk_i(clk), .rst_ni(rst_r_n), .led_we_i(led_we_r), .led_idx_i(led_idx_r),
    .led_rgb_i(led_rgb_r), .update_i(update_r), .busy_o(busy_r), .go_o(go_r),
    .data_o(data_r), .data_valid_o(valid_r), .data_last_o(last_r),
    .data_ack_i(ack_r), .idle_i(idle_r)
  );

  // Wire order is green, red, blue.
  function automatic logic [23:0] grb(input logic [23:0] c);
    int r, g, b;
    r = (c >> 16) & 255;
    g = (c >> 8) & 255;
    b = c & 255;
    return 24'(g * 65536 + r * 256 + b);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [23:0] v);
    led_we  = 1'b1;
    led_idx = 2'(idx);
    led_rgb = v;
    step();
    led_we  = 1'b0;
    if (idx < N) stg[idx] = v;
  endtask

  task automatic take_snap();
    for (int i = 0; i < N; i++) snap[i] = stg[i];
  endtask

  task automatic pulse_update();
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_n);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  // Plays the driver side of one frame: checks each LED word against the
  // snapshot, holds it a random time (with random system writes), then acks.
  task automatic run_frame(input bit poke);
    int hold;
    idle = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("go led%0d", i), go, 1);
      chk($sformatf("valid led%0d", i), valid, 1);
      chk($sformatf("data led%0d", i), data, grb(snap[i]));
      chk($sformatf("last led%0d", i), last, (i == N - 1));
      hold = $urandom_range(0, 3);
      if (poke && i == 0 && hold == 0) hold = 1;
      for (int h = 0; h < hold; h++) begin
        if (poke && i == 0 && h == 0) wr(1, 24'h000000);
        else if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 3), 24'($urandom));
        else step();
        chk($sformatf("hold data led%0d", i), data, grb(snap[i]));
        chk($sformatf("hold valid led%0d", i), valid, 1);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    chk("post valid", valid, 0);
    chk("post go", go, 0);
    chk("post last", last, 0);
    chk("post data", data, 0);
    chk("post busy", busy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t, tprev;
    logic [23:0] col;

    rst_n = 1'b0; rst_r_n = 1'b0;
    led_we = 1'b0; led_idx = '0; led_rgb = '0; update = 1'b0; ack = 1'b0; idle = 1'b1;
    led_we_r = 1'b0; led_idx_r = '0; led_rgb_r = '0; update_r = 1'b0; ack_r = 1'b0; idle_r = 1'b1;
    for (int i = 0; i < N; i++) stg[i] = '0;
    step();
    step();

    // Reset values.
    chk("rst go", go, 0);
    chk("rst valid", valid, 0);
    chk("rst last", last, 0);
    chk("rst data", data, 0);
    chk("rst busy", busy, 0);
    chk("rst_r busy", busy_r, 0);
    chk("rst_r valid", valid_r, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Basic frame, with a write to LED1 while LED0 is on the wire.
    wr(0, 24'h112233);
    wr(1, 24'hAABBCC);
    wr(2, 24'($urandom));
    chk("writes no frame busy", busy, 0);
    chk("writes no frame valid", valid, 0);
    take_snap();
    pulse_update();
    chk("req busy", busy, 1);
    chk("req valid", valid, 0);
    wait_valid("first latency", 1);
    chk("led0 literal", data, 24'h221133);
    run_frame(1'b1);

    // Driver not yet idle: sequencer must wait.
    repeat (3) step();
    chk("wait idle busy", busy, 1);
    chk("wait idle valid", valid, 0);

    // Update during the gap: one extra frame, right after gap + one idle cycle.
    idle = 1'b1;
    repeat (3) step();
    chk("gap busy", busy, 1);
    pulse_update();
    take_snap();
    chk("gap still quiet", valid, 0);
    wait_valid("gap latency", GAP + 2 - 4);
    run_frame(1'b0);
    idle = 1'b1;
    repeat (GAP + 2) step();
    chk("no extra frame busy", busy, 0);
    chk("no extra frame valid", valid, 0);

    // Out-of-range index is ignored and starts nothing.
    wr(3, 24'($urandom));
    repeat (5) step();
    chk("bad idx busy", busy, 0);
    chk("bad idx valid", valid, 0);
    take_snap();
    pulse_update();
    wait_valid("bad idx latency", 1);
    run_frame(1'b0);
    idle = 1'b1;
    repeat (GAP + 2) step();

    // Randomized rounds.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 6; k++) wr($urandom_range(0, 3), 24'($urandom));
      take_snap();
      pulse_update();
      wait_valid($sformatf("rand%0d latency", r), 1);
      run_frame(1'b0);
      repeat ($urandom_range(0, 3)) step();
      idle = 1'b1;
      repeat (GAP + 2) step();
      chk($sformatf("rand%0d end busy", r), busy, 0);
    end

    // Async reset in the middle of a frame.
    for (int i = 0; i < N; i++) wr(i, 24'($urandom) | 24'h010101);
    take_snap();
    pulse_update();
    wait_valid("pre-reset latency", 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("pre-reset led1", data, grb(snap[1]));
    #1 rst_n = 1'b0;
    #1;
    chk("async go", go, 0);
    chk("async valid", valid, 0);
    chk("async last", last, 0);
    chk("async data", data, 0);
    chk("async busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < N; i++) stg[i] = '0;
    idle = 1'b1;
    repeat (4) step();
    chk("no resume valid", valid, 0);
    chk("no resume busy", busy, 0);
    take_snap();
    pulse_update();
    wait_valid("post-reset latency", 1);
    run_frame(1'b0);
    idle = 1'b1;
    repeat (GAP + 2) step();

    // Auto-refresh on a single-LED chain.
    @(negedge clk) rst_r_n = 1'b1;
    col = 24'($urandom) | 24'h800000;
    led_we_r = 1'b1; led_idx_r = 1'b1; led_rgb_r = 24'($urandom);
    step();
    led_idx_r = 1'b0; led_rgb_r = col;
    step();
    led_we_r = 1'b0;
    step();
    chk("refresh idle busy", busy_r, 0);
    tprev = 0;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      while (valid_r !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      t = cyc;
      chk($sformatf("refresh%0d valid", f), valid_r, 1);
      if (f > 0) chk($sformatf("refresh%0d period", f), t - tprev, REF);
      chk($sformatf("refresh%0d data", f), data_r, grb(col));
      chk($sformatf("refresh%0d last", f), last_r, 1);
      chk($sformatf("refresh%0d go", f), go_r, 1);
      chk($sformatf("refresh%0d busy", f), busy_r, 1);
      ack_r = 1'b1;
      step();
      ack_r = 1'b0;
      chk($sformatf("refresh%0d done", f), valid_r, 0);
      repeat (20) step();
      chk($sformatf("refresh%0d between busy", f), busy_r, 0);
      tprev = t;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
